// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite responder: response codes, FSM state
// encodings and the byte-lane merge used on write commit.
package axi4_lite_pkg;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_GOT_ADDR,
    W_GOT_DATA,
    W_RESP
  } wr_state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4_lite_responder_beat_counter.sv
// Per-direction beat counter; pulses o_done for one cycle after every
// BLOCK_WORDS handshakes so both sides agree on block boundaries.
module beat_counter #(
  parameter int BLOCK_WORDS = 16
) (
  input  logic clk,
  input  logic arst,
  input  logic restartn,
  input  logic beat,
  output logic o_done
);

  localparam int CW = $clog2(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // Clear wins over a same-cycle beat and suppresses its pulse.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (!restartn) begin
      cnt_d = '0;
    end else if (beat) begin
      cnt_d  = cnt_q + 1'b1;
      done_d = (cnt_q == LAST);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign o_done = done_q;

endmodule

// File: rtl/axi4_lite_responder.sv
// AXI4-Lite responder over a small word-addressed register memory, with
// per-direction block-done pulses. All outputs come from flops or state.
module axi4_lite_responder
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 16,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  restartn,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  o_rd_done,
  output logic                  o_wr_done
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_DEPTH * 4);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

  rd_state_t             rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_t                 rresp_q, rresp_d;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_in_range;

  wr_state_t             wr_state_q, wr_state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [3:0]            wr_strb_q, wr_strb_d;
  resp_t                 bresp_q, bresp_d;

  logic                  commit;
  logic [ADDR_WIDTH-1:0] cm_addr;
  logic [DATA_WIDTH-1:0] cm_data;
  logic [3:0]            cm_strb;
  logic [IDX_W-1:0]      cm_idx;
  logic                  cm_in_range;

  // Read side: sample memory on AR accept, hold the result until R completes.
  always_comb begin
    rd_state_d  = rd_state_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    arready     = 1'b0;
    rvalid      = 1'b0;
    rd_idx      = araddr[2 +: IDX_W];
    rd_in_range = (araddr < ADDR_LIMIT);
    unique case (rd_state_q)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          rdata_d    = rd_in_range ? mem_q[rd_idx] : '0;
          rresp_d    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write side: AW and W may arrive in either order; the commit uses the
  // live channel for whichever half arrives last and the latch for the other.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    bresp_d    = bresp_q;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    commit     = 1'b0;
    cm_addr    = wr_addr_q;
    cm_data    = wr_data_q;
    cm_strb    = wr_strb_q;
    unique case (wr_state_q)
      W_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (awvalid && wvalid) begin
          commit     = 1'b1;
          cm_addr    = awaddr;
          cm_data    = wdata;
          cm_strb    = wstrb;
          wr_state_d = W_RESP;
        end else if (awvalid) begin
          wr_addr_d  = awaddr;
          wr_state_d = W_GOT_ADDR;
        end else if (wvalid) begin
          wr_data_d  = wdata;
          wr_strb_d  = wstrb;
          wr_state_d = W_GOT_DATA;
        end
      end
      W_GOT_ADDR: begin
        wready = 1'b1;
        if (wvalid) begin
          commit     = 1'b1;
          cm_data    = wdata;
          cm_strb    = wstrb;
          wr_state_d = W_RESP;
        end
      end
      W_GOT_DATA: begin
        awready = 1'b1;
        if (awvalid) begin
          commit     = 1'b1;
          cm_addr    = awaddr;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
    cm_idx      = cm_addr[2 +: IDX_W];
    cm_in_range = (cm_addr < ADDR_LIMIT);
    if (commit) bresp_d = cm_in_range ? RESP_OKAY : RESP_SLVERR;
  end

  // Reads see mem_q, so a same-edge read of the committed word gets old data.
  always_comb begin
    mem_d = mem_q;
    if (commit && cm_in_range) begin
      mem_d[cm_idx] = merge_bytes(mem_q[cm_idx], cm_data, cm_strb);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mem_q      <= '{default: '0};
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      wr_state_q <= W_IDLE;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      mem_q      <= mem_d;
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      bresp_q    <= bresp_d;
    end
  end

  assign rdata = rdata_q;
  assign rresp = rresp_q;
  assign bresp = bresp_q;

  beat_counter #(.BLOCK_WORDS(BLOCK_WORDS)) u_rd_cnt (
    .clk      (clk),
    .arst     (arst),
    .restartn (restartn),
    .beat     (rvalid & rready),
    .o_done   (o_rd_done)
  );

  beat_counter #(.BLOCK_WORDS(BLOCK_WORDS)) u_wr_cnt (
    .clk      (clk),
    .arst     (arst),
    .restartn (restartn),
    .beat     (bvalid & bready),
    .o_done   (o_wr_done)
  );

endmodule

// File: doc/axi4_lite_responder.md
# axi4_lite_responder

AXI4-Lite slave (responder) backed by a small word-addressed register memory. It serves the memory side of the cache-line transfers whose beats the initiator side counts. For each direction it counts completed beats and pulses a block-done flag after every `BLOCK_WORDS` beats, so the memory model and the initiator agree on block boundaries.

## Interface

**Parameters**
- `ADDR_WIDTH`, 32, AXI address width.
- `DATA_WIDTH`, 32, data width; fixed at 32 in this revision, so 4 byte lanes.
- `MEM_DEPTH`, 16, number of words in the backing memory; power of two.
- `BLOCK_WORDS`, 16, beats per block for the done pulses; power of two, ≥ 2.

**Ports**
- `clk` in 1: clock.
- `arst` in 1: reset, asynchronous, active-high.
- `restartn` in 1: synchronous active-low clear of both beat counters.
- `araddr` in `ADDR_WIDTH`; `arvalid` in 1; `arready` out 1.
- `rdata` out `DATA_WIDTH`; `rresp` out 2; `rvalid` out 1; `rready` in 1.
- `awaddr` in `ADDR_WIDTH`; `awvalid` in 1; `awready` out 1.
- `wdata` in `DATA_WIDTH`; `wstrb` in 4; `wvalid` in 1; `wready` out 1.
- `bresp` out 2; `bvalid` out 1; `bready` in 1.
- `o_rd_done` out 1: one-cycle pulse, read block complete.
- `o_wr_done` out 1: one-cycle pulse, write block complete.

## Operation

**Addressing**
- Word index = `addr[2 +: $clog2(MEM_DEPTH)]`.
- An address is in range iff `addr < MEM_DEPTH*4`. Low two address bits are ignored.
- Out-of-range read: `rdata = 0`, `rresp = SLVERR (2'b10)`.
- Out-of-range write: memory unchanged, `bresp = SLVERR`.
- In range: response is `OKAY (2'b00)`.

**Read FSM** (states `R_IDLE`, `R_DATA`)
- `R_IDLE`: `arready = 1`. On `arvalid`, capture `rdata`/`rresp` from memory and go to `R_DATA`.
- `R_DATA`: `arready = 0`, `rvalid = 1`. `rdata`/`rresp` are held stable until `rready`, then return to `R_IDLE`.

**Write FSM** (states `W_IDLE`, `W_GOT_ADDR`, `W_GOT_DATA`, `W_RESP`)
- `W_IDLE`: `awready = wready = 1`. AW and W are accepted independently.
  - Both handshakes in the same cycle → commit the write, go to `W_RESP`.
  - AW only → latch address, go to `W_GOT_ADDR`.
  - W only → latch data and strobe, go to `W_GOT_DATA`.
- `W_GOT_ADDR`: only `wready = 1`. On W handshake, commit and go to `W_RESP`.
- `W_GOT_DATA`: only `awready = 1`. On AW handshake, commit and go to `W_RESP`.
- `W_RESP`: `bvalid = 1`, `bresp` held. On `bready`, go to `W_IDLE`.
- Commit: byte lane `i` is written iff `wstrb[i]`. `wstrb = 0` is legal: no change, `OKAY`.

**Beat counters**
- Read counter increments on each R handshake (`rvalid & rready`).
- Write counter increments on each B handshake (`bvalid & bready`).
- Counter width is `$clog2(BLOCK_WORDS)`; counters wrap to 0 after `BLOCK_WORDS-1`.
- `restartn = 0` clears a counter to 0; this has priority over an increment in the same cycle.
- A handshake that occurs while the counter equals `BLOCK_WORDS-1`, with `restartn = 1`, asserts the matching `o_*_done` for exactly the next cycle.

**Reset (`arst`)**
- Both FSMs return to IDLE, memory is zeroed, and counters are cleared.
- `rvalid`, `bvalid`, `o_rd_done`, `o_wr_done` = 0; `rdata` = 0; `rresp`, `bresp` = `OKAY`.
- `arready`, `awready`, `wready` decode from the IDLE states, so they are 1 after reset.
- `arst` in the middle of a transaction drops the pending transaction: no response is issued.

## Timing
- Ready signals are decoded from FSM state. There is no combinational path from any input to any output.
- Read: AR handshake at edge N → `rvalid` high from cycle N+1. Maximum throughput is one read per 2 cycles.
- Write: last of AW/W handshake at edge N → memory updated at edge N, `bvalid` high from cycle N+1.
- Read and write FSMs are fully independent.
- Same-edge AR handshake and write commit to the same word: the read returns the old value.
- A read accepted after the commit edge returns the new value.
- Done pulse: final handshake at edge N → `o_*_done` high during cycle N+1 only.

## Structure
- Package `axi4_lite_pkg` holds:
  - `resp_t` with constants `RESP_OKAY = 2'b00` and `RESP_SLVERR = 2'b10`.
  - Enums `rd_state_t` and `wr_state_t`.
- Sub-module `beat_counter` (params `BLOCK_WORDS`; ports `clk`, `arst`, `restartn`, `beat`, `o_done`), instantiated twice.

## Test plan
- Reset, then read address `0x8`: `rvalid` in the cycle after AR, `rdata = 0`, `rresp = OKAY`.
- AW `0x4` one cycle before W `0xDEADBEEF` with `wstrb = 4'b0011`, after a prior full write of `0xFFFFFFFF`: `bvalid` the cycle after W; readback returns `0xFFFFBEEF`.
- Read `0x40` (with `MEM_DEPTH = 16`): `rresp = SLVERR`, `rdata = 0`. Write to `0x40`: `bresp = SLVERR`, memory unchanged.
- `rready` held low 5 cycles in `R_DATA`: `rvalid` and `rdata` stay stable, and `arready` stays 0 throughout.
- 16 back-to-back reads: `o_rd_done` is high for exactly the one cycle after the 16th R handshake. A 17th read produces no pulse.
- `restartn = 0` pulsed after 10 writes, then 16 more writes: `o_wr_done` pulses only after the 16th post-clear B handshake. `arst` asserted in `W_RESP`: `bvalid` drops immediately and no response follows.
